// File: rtl/lane_pkg.sv
// Shared types for the lane mover: FSM state encoding and move direction codes.
package lane_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM_L = 2'd1,
    ARM_R = 2'd2,
    MOVE  = 2'd3
  } lane_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchroniser, stable-sample debounce, registered edge pulses.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Level flips once the synchronised input has differed from it for DB_CYCLES samples.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      rise      <= 1'b0;
      fall      <= 1'b0;
      if (sync_q != level) begin
        if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          level <= sync_q;
          cnt   <= '0;
          rise  <= sync_q;
          fall  <= ~sync_q;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lane_mover.sv
// Player lane controller: debounced Left/Right press-release moves the character one
// lane, followed by a timed move phase. Define LANE_MOVER_WRAP_EN to wrap at the edges
// instead of saturating.
module lane_mover
  import lane_pkg::*;
#(
  parameter  int unsigned NUM_POS     = 4,
  parameter  int unsigned DB_CYCLES   = 16,
  parameter  int unsigned MOVE_CYCLES = 8,
  localparam int unsigned POS_W       = $clog2(NUM_POS),
  localparam int unsigned STEP_W      = $clog2(MOVE_CYCLES + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LeftIn,
  input  logic              RightIn,
  output logic [POS_W-1:0]  CurrPos,
  output logic [POS_W-1:0]  PrevPos,
  output logic              Moving,
  output logic              MoveDir,
  output logic [STEP_W-1:0] MoveStep
);

  logic l_lvl, l_rise, l_fall;
  logic r_lvl, r_rise, r_fall;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_left (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (LeftIn),
    .level (l_lvl),
    .rise  (l_rise),
    .fall  (l_fall)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_right (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (RightIn),
    .level (r_lvl),
    .rise  (r_rise),
    .fall  (r_fall)
  );

  lane_state_e       state, state_nxt;
  logic [POS_W-1:0]  curr_nxt, prev_nxt;
  logic              moving_nxt, dir_nxt;
  logic [STEP_W-1:0] step_nxt;
  logic [POS_W-1:0]  left_tgt, right_tgt;
  logic              left_ok, right_ok;

  // Neighbouring lanes and whether a move there is allowed from the current lane.
  always_comb begin
    left_ok   = 1'b1;
    right_ok  = 1'b1;
    left_tgt  = CurrPos - POS_W'(1);
    right_tgt = CurrPos + POS_W'(1);
    if (CurrPos == '0) begin
`ifdef LANE_MOVER_WRAP_EN
      left_tgt = POS_W'(NUM_POS - 1);
`else
      left_ok  = 1'b0;
      left_tgt = CurrPos;
`endif
    end
    if (CurrPos == POS_W'(NUM_POS - 1)) begin
`ifdef LANE_MOVER_WRAP_EN
      right_tgt = '0;
`else
      right_ok  = 1'b0;
      right_tgt = CurrPos;
`endif
    end
  end

  // Next state and next registered outputs; a commit happens on the ARM_x -> MOVE edge.
  always_comb begin
    state_nxt  = state;
    curr_nxt   = CurrPos;
    prev_nxt   = PrevPos;
    moving_nxt = Moving;
    dir_nxt    = MoveDir;
    step_nxt   = MoveStep;
    case (state)
      IDLE: begin
        if (l_rise && !r_lvl) begin
          state_nxt = ARM_L;
        end else if (r_rise && !l_lvl) begin
          state_nxt = ARM_R;
        end
      end
      ARM_L: begin
        if (r_lvl) begin
          state_nxt = IDLE;
        end else if (l_fall) begin
          if (left_ok) begin
            state_nxt  = MOVE;
            prev_nxt   = CurrPos;
            curr_nxt   = left_tgt;
            dir_nxt    = DIR_LEFT;
            moving_nxt = 1'b1;
            step_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      ARM_R: begin
        if (l_lvl) begin
          state_nxt = IDLE;
        end else if (r_fall) begin
          if (right_ok) begin
            state_nxt  = MOVE;
            prev_nxt   = CurrPos;
            curr_nxt   = right_tgt;
            dir_nxt    = DIR_RIGHT;
            moving_nxt = 1'b1;
            step_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      MOVE: begin
        if (MoveStep == STEP_W'(MOVE_CYCLES - 1)) begin
          state_nxt  = IDLE;
          moving_nxt = 1'b0;
          step_nxt   = '0;
        end else begin
          step_nxt = MoveStep + STEP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      CurrPos  <= '0;
      PrevPos  <= '0;
      Moving   <= 1'b0;
      MoveDir  <= 1'b0;
      MoveStep <= '0;
    end else begin
      state    <= state_nxt;
      CurrPos  <= curr_nxt;
      PrevPos  <= prev_nxt;
      Moving   <= moving_nxt;
      MoveDir  <= dir_nxt;
      MoveStep <= step_nxt;
    end
  end

endmodule

// File: tb/tb_lane_mover.sv
// Bench for lane_mover (DB_CYCLES=4, MOVE_CYCLES=3). Expected commits are queued by the
// stimulus; a monitor pops and checks them whenever Moving rises. Honours LANE_MOVER_WRAP_EN.
module tb_lane_mover;

  localparam int NUM_POS     = 4;
  localparam int DB_CYCLES   = 4;
  localparam int MOVE_CYCLES = 3;

  logic       Clock;
  logic       Reset;
  logic       LeftIn;
  logic       RightIn;
  logic [1:0] CurrPos;
  logic [1:0] PrevPos;
  logic       Moving;
  logic       MoveDir;
  logic [1:0] MoveStep;

  lane_mover #(
    .NUM_POS     (NUM_POS),
    .DB_CYCLES   (DB_CYCLES),
    .MOVE_CYCLES (MOVE_CYCLES)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .LeftIn   (LeftIn),
    .RightIn  (RightIn),
    .CurrPos  (CurrPos),
    .PrevPos  (PrevPos),
    .Moving   (Moving),
    .MoveDir  (MoveDir),
    .MoveStep (MoveStep)
  );

  typedef struct {
    int curr;
    int prev;
    int dir;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pos_m = 0;
  int   prev_m = 0;
  bit   abort_run = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Expected outcome of a completed press/release, from the bench's own lane model.
  function automatic void expect_move(input bit right);
    int  tgt;
    bit  ok;
    ok = 1'b1;
    if (right) begin
      if (pos_m == NUM_POS - 1) begin
`ifdef LANE_MOVER_WRAP_EN
        tgt = 0;
`else
        ok = 1'b0; tgt = pos_m;
`endif
      end else tgt = pos_m + 1;
    end else begin
      if (pos_m == 0) begin
`ifdef LANE_MOVER_WRAP_EN
        tgt = NUM_POS - 1;
`else
        ok = 1'b0; tgt = pos_m;
`endif
      end else tgt = pos_m - 1;
    end
    if (ok) begin
      q.push_back('{curr: tgt, prev: pos_m, dir: int'(right)});
      prev_m = pos_m;
      pos_m  = tgt;
    end
  endfunction

  task automatic press(input bit right, input int hold);
    if (right) RightIn = 1'b1; else LeftIn = 1'b1;
    tick(hold);
    if (right) RightIn = 1'b0; else LeftIn = 1'b0;
    expect_move(right);
    tick(15);
    check("pos_after_press", int'(CurrPos), pos_m);
    check("prev_after_press", int'(PrevPos), prev_m);
  endtask

  // Monitor: checks each commit against the queue, step progression and phase length.
  int  run = 0;
  bit  moving_q = 1'b0;
  always @(negedge Clock) begin
    if (Moving) begin
      if (!moving_q) begin
        abort_run = 1'b0;
        if (q.size() == 0) begin
          check("unexpected_move", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("commit_curr", int'(CurrPos), e.curr);
          check("commit_prev", int'(PrevPos), e.prev);
          check("commit_dir", int'(MoveDir), e.dir);
        end
      end
      check("move_step", int'(MoveStep), run);
      run++;
    end else if (moving_q) begin
      if (!abort_run) check("moving_len", run, MOVE_CYCLES);
      run = 0;
    end
    moving_q = Moving;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    Reset   = 1'b0;
    LeftIn  = 1'b0;
    RightIn = 1'b0;
    tick(3);
    check("rst_curr", int'(CurrPos), 0);
    check("rst_prev", int'(PrevPos), 0);
    check("rst_moving", int'(Moving), 0);
    check("rst_dir", int'(MoveDir), 0);
    check("rst_step", int'(MoveStep), 0);
    Reset = 1'b1;
    tick(2);

    // Basic right move 0 -> 1.
    press(1'b1, 10);
    check("first_dir", int'(MoveDir), 1);

    // Short glitches never reach the debounced level.
    for (int i = 0; i < 4; i++) begin
      RightIn = 1'b1; tick(1);
      RightIn = 1'b0; tick(2);
    end
    tick(12);
    check("glitch_pos", int'(CurrPos), pos_m);
    check("glitch_moving", int'(Moving), 0);

    // Walk to the right edge, then try to go past it.
    press(1'b1, 10);
    press(1'b1, 10);
    press(1'b1, 10);
    // Walk left across and past the left edge.
    for (int i = 0; i < 4; i++) press(1'b0, 10);

    // Left held, Right pressed before Left released: cancel.
    LeftIn = 1'b1;  tick(10);
    RightIn = 1'b1; tick(10);
    LeftIn = 1'b0;  tick(10);
    RightIn = 1'b0; tick(12);
    check("cancel_pos", int'(CurrPos), pos_m);
    check("cancel_prev", int'(PrevPos), prev_m);

    // Left press lands during the move phase and must be ignored.
    RightIn = 1'b1; tick(10);
    RightIn = 1'b0;
    expect_move(1'b1);
    tick(2);
    LeftIn = 1'b1; tick(10);
    LeftIn = 1'b0; tick(15);
    check("ignore_pos", int'(CurrPos), pos_m);
    check("ignore_prev", int'(PrevPos), prev_m);

    // Reset asserted while MoveStep is 1.
    RightIn = 1'b1; tick(10);
    RightIn = 1'b0;
    expect_move(1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge Clock);
      if (Moving && MoveStep == 2'd1) found = 1'b1;
    end
    check("step1_reached", int'(found), 1);
    abort_run = 1'b1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("midmove_rst_curr", int'(CurrPos), 0);
    check("midmove_rst_prev", int'(PrevPos), 0);
    check("midmove_rst_moving", int'(Moving), 0);
    check("midmove_rst_dir", int'(MoveDir), 0);
    check("midmove_rst_step", int'(MoveStep), 0);
    pos_m = 0; prev_m = 0;
    tick(2);
    Reset = 1'b1;
    tick(3);

    // Reset while armed: released key afterwards must not commit.
    RightIn = 1'b1; tick(10);
    Reset = 1'b0;
    RightIn = 1'b0; tick(3);
    Reset = 1'b1; tick(15);
    check("midarm_pos", int'(CurrPos), 0);
    check("midarm_moving", int'(Moving), 0);

    tick(5);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
